// File: rtl/rot_sched_if.sv
// Handshake bundle for rot_sched: two requester ports, one result port, status and counters.
// The master side (requesters plus consumer) drives valids, operands and out_ready.
interface rot_sched_if;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] a_data;
    logic [3:0] a_amt;
    logic       a_dir;

    logic       b_valid;
    logic       b_ready;
    logic [7:0] b_data;
    logic [3:0] b_amt;
    logic       b_dir;

    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_src;

    logic       busy;
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;

    modport master (
        output a_valid, a_data, a_amt, a_dir,
        output b_valid, b_data, b_amt, b_dir,
        output out_ready,
        input  a_ready, b_ready, out_valid, out_data, out_src, busy, cnt_a, cnt_b
    );

    modport slave (
        input  a_valid, a_data, a_amt, a_dir,
        input  b_valid, b_data, b_amt, b_dir,
        input  out_ready,
        output a_ready, b_ready, out_valid, out_data, out_src, busy, cnt_a, cnt_b
    );
endinterface

// File: rtl/rot_sched.sv
// Two-requester scheduler sharing one 8-bit rotator; amounts >= 8 take two passes.
// Define ROT_SCHED_STATS_EN to add saturating per-requester completion counters.
module rot_sched #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    rot_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS2 = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t     state;
    logic       out_valid_r;
    logic [7:0] out_data_r;
    logic       out_src_r;
    logic       busy_r;
    logic [7:0] stage_r;
    logic [2:0] amt2_r;
    logic       dir_r;
    logic       prio_b;

    logic       can_accept;
    logic       grant_a;
    logic       grant_b;
    logic       accept;
    logic [7:0] sel_data;
    logic [3:0] sel_amt;
    logic       sel_dir;

    logic [7:0]  rot_in;
    logic [2:0]  rot_amt;
    logic        rot_dir;
    logic [15:0] rot_l;
    logic [15:0] rot_r;
    logic [7:0]  rot_out;

    // Ready is forced low while reset is asserted, even though the FSM already sits in IDLE.
    assign can_accept = rst_n && ((state == IDLE) || ((state == HOLD) && bus.out_ready));

    assign grant_b = bus.b_valid && (!bus.a_valid || (RR_EN && prio_b));
    assign grant_a = bus.a_valid && !grant_b;
    assign accept  = can_accept && (bus.a_valid || bus.b_valid);

    assign bus.a_ready = can_accept && grant_a;
    assign bus.b_ready = can_accept && grant_b;

    assign sel_data = grant_b ? bus.b_data : bus.a_data;
    assign sel_amt  = grant_b ? bus.b_amt  : bus.a_amt;
    assign sel_dir  = grant_b ? bus.b_dir  : bus.a_dir;

    // The single rotator serves the first pass of a new op, or the second pass in PASS2.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        rot_in  = sel_data;
        rot_amt = sel_amt[3] ? 3'd7 : sel_amt[2:0];
        rot_dir = sel_dir;
        if (state == PASS2) begin
            rot_in  = stage_r;
            rot_amt = amt2_r;
            rot_dir = dir_r;
        end
        rot_l   = {rot_in, rot_in} << rot_amt;
        rot_r   = {rot_in, rot_in} >> rot_amt;
        rot_out = rot_dir ? rot_l[15:8] : rot_r[7:0];
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
            out_src_r   <= 1'b0;
            busy_r      <= 1'b0;
            stage_r     <= 8'h00;
            amt2_r      <= 3'd0;
            dir_r       <= 1'b0;
            prio_b      <= 1'b0;
        end else if (accept) begin
            busy_r    <= 1'b1;
            out_src_r <= grant_b;
            prio_b    <= grant_a;
            if (sel_amt[3]) begin
                // 7 now, then (amt+1) mod 8 next cycle: 7 + amt + 1 == amt (mod 8).
                state       <= PASS2;
                out_valid_r <= 1'b0;
                stage_r     <= rot_out;
                amt2_r      <= sel_amt[2:0] + 3'd1;
                dir_r       <= sel_dir;
            end else begin
                state       <= HOLD;
                out_valid_r <= 1'b1;
                out_data_r  <= rot_out;
            end
        end else begin
            case (state)
                PASS2: begin
                    state       <= HOLD;
                    out_valid_r <= 1'b1;
                    out_data_r  <= rot_out;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_src   = out_src_r;
    assign bus.busy      = busy_r;

`ifdef ROT_SCHED_STATS_EN
    logic [7:0] cnt_a_r;
    logic [7:0] cnt_b_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_r <= 8'h00;
            cnt_b_r <= 8'h00;
        end else if (out_valid_r && bus.out_ready) begin
            if (out_src_r) begin
                if (cnt_b_r != 8'hFF) cnt_b_r <= cnt_b_r + 8'd1;
            end else begin
                if (cnt_a_r != 8'hFF) cnt_a_r <= cnt_a_r + 8'd1;
            end
        end
    end

    assign bus.cnt_a = cnt_a_r;
    assign bus.cnt_b = cnt_b_r;
`else
    assign bus.cnt_a = 8'h00;
    assign bus.cnt_b = 8'h00;
`endif

endmodule
